avl_mem_arbiter: RTL and testbench

- Two-port Avalon-MM master that sits directly upstream of the bus memory slave.
- Merges the CPU instruction-fetch port and load/store data port onto one Avalon master interface.
- Issues one transaction at a time, honours waitrequest, and returns read data plus a one-cycle acknowledge to the requesting port.
- Fair arbitration and a bus timeout keep the CPU from hanging on a dead slave.

---
 rtl/avl_mem_arbiter_if.sv | 41 ++++
 rtl/avl_mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_avl_mem_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avl_mem_arbiter_if.sv
// CPU-side fetch/data ports and Avalon-MM master bus of the memory arbiter.
// master = arbiter view, slave = CPU + memory environment view.
interface avl_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_byteenable;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        err;
    logic [31:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_byteenable, d_wdata,
        input  avm_readdata, avm_waitrequest,
        output i_rdata, i_ack, d_rdata, d_ack, err,
        output avm_address, avm_byteenable, avm_writedata,
        output avm_read, avm_write
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_byteenable, d_wdata,
        output avm_readdata, avm_waitrequest,
        input  i_rdata, i_ack, d_rdata, d_ack, err,
        input  avm_address, avm_byteenable, avm_writedata,
        input  avm_read, avm_write
    );
endinterface

// File: rtl/avl_mem_arbiter.sv
// Two-port (fetch/data) Avalon-MM master: one transaction at a time,
// alternating priority on ties, bus timeout with error acknowledge.
module avl_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    avl_mem_arbiter_if.master bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

    state_e      state_q, state_d;
    logic        gnt_data_q, gnt_data_d;
    logic        last_data_q, last_data_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_ack_q, i_ack_d;
    logic        d_ack_q, d_ack_d;
    logic        err_q, err_d;

    logic any_req;
    logic pick_data;
    logic timeout_hit;

    assign any_req   = bus.i_req | bus.d_req;
    // On a tie the port that did not win last time gets the bus.
    assign pick_data = bus.d_req & (~bus.i_req | ~last_data_q);
    assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) &&
                         (cnt_q + 32'd1 == TIMEOUT_CYCLES);

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (any_req) state_d = ISSUE;
            ISSUE: if (!bus.avm_waitrequest || timeout_hit) state_d = RESP;
            RESP:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        err_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    cnt_d       = '0;
                    if (pick_data) begin
                        addr_d  = {bus.d_addr[31:2], 2'b00};
                        be_d    = bus.d_byteenable;
                        wdata_d = bus.d_wdata;
                        rd_d    = ~bus.d_we;
                        wr_d    = bus.d_we;
                    end else begin
                        addr_d  = {bus.i_addr[31:2], 2'b00};
                        be_d    = 4'b1111;
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (!bus.avm_waitrequest) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    i_ack_d = ~gnt_data_q;
                    d_ack_d = gnt_data_q;
                    if (rd_q && gnt_data_q)  d_rdata_d = bus.avm_readdata;
                    if (rd_q && !gnt_data_q) i_rdata_d = bus.avm_readdata;
                end else if (timeout_hit) begin
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    i_ack_d = ~gnt_data_q;
                    d_ack_d = gnt_data_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            RESP: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            err_q       <= err_d;
        end
    end

    assign bus.avm_address    = addr_q;
    assign bus.avm_byteenable = be_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_read       = rd_q;
    assign bus.avm_write      = wr_q;
    assign bus.i_rdata        = i_rdata_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.i_ack          = i_ack_q;
    assign bus.d_ack          = d_ack_q;
    assign bus.err            = err_q;

endmodule

// File: tb/tb_avl_mem_arbiter.sv
// Directed bench for avl_mem_arbiter against a 16-word memory slave
// that holds waitrequest for two cycles per access.
module tb_avl_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    avl_mem_arbiter_if bus();

    avl_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [16];
    logic [1:0]  wcnt;
    bit          dead = 1'b0;

    assign bus.avm_waitrequest = dead |
        ((bus.avm_read | bus.avm_write) && (wcnt < 2'd2));
    assign bus.avm_readdata = mem[bus.avm_address[5:2]];

    always @(posedge clk) begin
        if (rst || dead || !(bus.avm_read || bus.avm_write)) begin
            wcnt <= 2'd0;
        end else if (wcnt < 2'd2) begin
            wcnt <= wcnt + 2'd1;
        end else begin
            wcnt <= 2'd0;
            if (bus.avm_write)
                for (int b = 0; b < 4; b++)
                    if (bus.avm_byteenable[b])
                        mem[bus.avm_address[5:2]][8*b +: 8] <=
                            bus.avm_writedata[8*b +: 8];
        end
    end

    always @(negedge clk) begin
        checks++;
        if (bus.avm_read === 1'b1 && bus.avm_write === 1'b1) begin
            errors++;
            $display("FAIL rd_wr_excl at %0t: read=1 write=1 required not both", $time);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.i_req = 1'b0;
        bus.i_addr = '0;
        bus.d_req = 1'b0;
        bus.d_we = 1'b0;
        bus.d_addr = '0;
        bus.d_byteenable = '0;
        bus.d_wdata = '0;
    endtask

    // Waits for the chosen ack; cyc stays -1 if it never arrives.
    task automatic wait_ack(input bit data, input int cur, input int maxc,
                            output int cyc, output logic e);
        cyc = -1;
        e = 1'b0;
        for (int c = cur + 1; c <= maxc; c++) begin
            tick;
            if ((data ? bus.d_ack : bus.i_ack) === 1'b1) begin
                cyc = c;
                e = bus.err;
                break;
            end
        end
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({bus.avm_read, bus.avm_write, bus.i_ack, bus.d_ack, bus.err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b required 00000",
                     {bus.avm_read, bus.avm_write, bus.i_ack, bus.d_ack, bus.err});
        end
        checks++;
        if (bus.avm_address !== 32'h0 || bus.avm_byteenable !== 4'h0 ||
            bus.avm_writedata !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus got addr=%h be=%h wd=%h required zeros",
                     bus.avm_address, bus.avm_byteenable, bus.avm_writedata);
        end
        checks++;
        if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata got i=%h d=%h required 0", bus.i_rdata, bus.d_rdata);
        end
        tick;
    endtask

    task automatic test_fetch;
        int cyc;
        logic e;
        bus.i_req = 1'b1;
        bus.i_addr = 32'hBFC00000;
        tick;
        checks++;
        if (bus.avm_read !== 1'b1 || bus.avm_byteenable !== 4'hF ||
            bus.avm_address !== 32'hBFC00000) begin
            errors++;
            $display("FAIL fetch_issue got rd=%b be=%h addr=%h required 1 f bfc00000",
                     bus.avm_read, bus.avm_byteenable, bus.avm_address);
        end
        wait_ack(1'b0, 1, 10, cyc, e);
        bus.i_req = 1'b0;
        checks++;
        if (cyc !== 4 || e !== 1'b0) begin
            errors++;
            $display("FAIL fetch_ack got cycle=%0d err=%b required 4 0", cyc, e);
        end
        checks++;
        if (bus.i_rdata !== 32'h3C011234) begin
            errors++;
            $display("FAIL fetch_data got %h required 3c011234", bus.i_rdata);
        end
        tick;
    endtask

    task automatic test_write_read;
        int cyc;
        logic e;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h00000013;
        bus.d_byteenable = 4'b0011;
        bus.d_wdata = 32'hAABBCCDD;
        tick;
        checks++;
        if (bus.avm_address !== 32'h10 || bus.avm_write !== 1'b1 ||
            bus.avm_read !== 1'b0 || bus.avm_byteenable !== 4'b0011 ||
            bus.avm_writedata !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL wr_issue got a=%h w=%b r=%b be=%h wd=%h required 10 1 0 3 aabbccdd",
                     bus.avm_address, bus.avm_write, bus.avm_read,
                     bus.avm_byteenable, bus.avm_writedata);
        end
        wait_ack(1'b1, 1, 10, cyc, e);
        bus.d_req = 1'b0;
        checks++;
        if (cyc !== 4 || e !== 1'b0 || bus.d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL wr_ack got cycle=%0d err=%b d_rdata=%h required 4 0 0",
                     cyc, e, bus.d_rdata);
        end
        tick;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_byteenable = 4'b1111;
        wait_ack(1'b1, 0, 10, cyc, e);
        bus.d_req = 1'b0;
        checks++;
        if (cyc !== 4 || bus.d_rdata !== 32'h0000CCDD) begin
            errors++;
            $display("FAIL rd_back got cycle=%0d data=%h required 4 0000ccdd",
                     cyc, bus.d_rdata);
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int acyc[$];
        bit aport[$];
        int overlap = 0;
        do_reset();
        bus.i_addr = 32'hBFC00000;
        bus.d_addr = 32'h00000010;
        bus.d_we = 1'b0;
        bus.d_byteenable = 4'hF;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick;
            if (bus.i_ack === 1'b1 && bus.d_ack === 1'b1) overlap++;
            if (bus.d_ack === 1'b1) begin acyc.push_back(c); aport.push_back(1'b1); end
            else if (bus.i_ack === 1'b1) begin acyc.push_back(c); aport.push_back(1'b0); end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        checks++;
        if (overlap != 0 || acyc.size() != 3) begin
            errors++;
            $display("FAIL b2b_count got acks=%0d overlap=%0d required 3 0",
                     acyc.size(), overlap);
        end else begin
            checks++;
            if (acyc[0] != 4 || acyc[1] != 9 || acyc[2] != 14) begin
                errors++;
                $display("FAIL b2b_cycles got %0d %0d %0d required 4 9 14",
                         acyc[0], acyc[1], acyc[2]);
            end
            checks++;
            if ({aport[0], aport[1], aport[2]} !== 3'b101) begin
                errors++;
                $display("FAIL b2b_order got %b required 101 (D I D)",
                         {aport[0], aport[1], aport[2]});
            end
        end
        checks++;
        if (bus.i_rdata !== 32'h3C011234 || bus.d_rdata !== 32'h0000CCDD) begin
            errors++;
            $display("FAIL b2b_data got i=%h d=%h required 3c011234 0000ccdd",
                     bus.i_rdata, bus.d_rdata);
        end
        tick;
        checks++;
        if (bus.avm_read !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got rd=%b required 0", bus.avm_read);
        end
    endtask

    task automatic test_timeout;
        int held = 0;
        dead = 1'b1;
        bus.d_req = 1'b1;
        bus.d_we = 1'b0;
        bus.d_addr = 32'h00000020;
        bus.d_byteenable = 4'hF;
        for (int c = 1; c <= 8; c++) begin
            tick;
            if (bus.avm_read === 1'b1 && bus.d_ack === 1'b0) held++;
        end
        checks++;
        if (held != 8) begin
            errors++;
            $display("FAIL to_hold got %0d issue cycles required 8", held);
        end
        tick;
        bus.d_req = 1'b0;
        checks++;
        if (bus.avm_read !== 1'b0 || bus.d_ack !== 1'b1 || bus.err !== 1'b1) begin
            errors++;
            $display("FAIL to_abort got rd=%b ack=%b err=%b required 0 1 1",
                     bus.avm_read, bus.d_ack, bus.err);
        end
        checks++;
        if (bus.d_rdata !== 32'h0000CCDD) begin
            errors++;
            $display("FAIL to_rdata got %h required 0000ccdd", bus.d_rdata);
        end
        dead = 1'b0;
        tick;
        checks++;
        if (bus.d_ack !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse got ack=%b err=%b required 0 0", bus.d_ack, bus.err);
        end
    endtask

    task automatic test_reset_mid;
        int acks = 0;
        int cyc;
        logic e;
        bus.i_req = 1'b1;
        bus.i_addr = 32'hBFC00000;
        tick;
        tick;
        rst = 1'b1;
        bus.i_req = 1'b0;
        tick;
        rst = 1'b0;
        checks++;
        if (bus.avm_read !== 1'b0 || bus.i_ack !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_drop got rd=%b ack=%b required 0 0",
                     bus.avm_read, bus.i_ack);
        end
        for (int c = 0; c < 4; c++) begin
            tick;
            if (bus.i_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL rstmid_noack got %0d acks required 0", acks);
        end
        bus.i_req = 1'b1;
        wait_ack(1'b0, 0, 10, cyc, e);
        bus.i_req = 1'b0;
        checks++;
        if (cyc !== 4 || bus.i_rdata !== 32'h3C011234) begin
            errors++;
            $display("FAIL rstmid_fresh got cycle=%0d data=%h required 4 3c011234",
                     cyc, bus.i_rdata);
        end
        tick;
    endtask

    task automatic test_drop;
        int acks = 0;
        int first = -1;
        int wr_held = 0;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h00000030;
        bus.d_byteenable = 4'hF;
        bus.d_wdata = 32'h12345678;
        tick;
        bus.d_req = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            tick;
            if (bus.avm_write === 1'b1) wr_held++;
        end
        checks++;
        if (wr_held != 2) begin
            errors++;
            $display("FAIL drop_hold got %0d cycles of write required 2", wr_held);
        end
        for (int c = 4; c <= 9; c++) begin
            tick;
            if (bus.d_ack === 1'b1) begin
                acks++;
                if (first < 0) first = c;
            end
        end
        checks++;
        if (acks != 1 || first != 4) begin
            errors++;
            $display("FAIL drop_ack got acks=%0d first=%0d required 1 4", acks, first);
        end
        checks++;
        if (mem[12] !== 32'h12345678 || bus.avm_write !== 1'b0) begin
            errors++;
            $display("FAIL drop_mem got mem=%h wr=%b required 12345678 0",
                     mem[12], bus.avm_write);
        end
    endtask

    task automatic test_be_zero;
        int cyc;
        logic e;
        bus.d_req = 1'b1;
        bus.d_we = 1'b1;
        bus.d_addr = 32'h00000012;
        bus.d_byteenable = 4'b0000;
        bus.d_wdata = 32'hFFFFFFFF;
        tick;
        checks++;
        if (bus.avm_byteenable !== 4'b0000 || bus.avm_write !== 1'b1 ||
            bus.avm_address !== 32'h10) begin
            errors++;
            $display("FAIL be0_issue got be=%h wr=%b a=%h required 0 1 10",
                     bus.avm_byteenable, bus.avm_write, bus.avm_address);
        end
        wait_ack(1'b1, 1, 10, cyc, e);
        bus.d_req = 1'b0;
        checks++;
        if (cyc !== 4 || mem[4] !== 32'h0000CCDD) begin
            errors++;
            $display("FAIL be0_done got cycle=%0d mem=%h required 4 0000ccdd",
                     cyc, mem[4]);
        end
        tick;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h3C011234;
        idle_inputs();
        test_reset();
        test_fetch();
        test_write_read();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_drop();
        test_be_zero();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
